wb_sdr_pattern_master: RTL
==========================

# wb_sdr_pattern_master

Synthesisable, parametrised Wishbone master that exercises the SDRAM controller's Wishbone slave port with pseudo-random write/read-back traffic and checks the returned data. It sits on the `sys_clk` side, in place of the bench-driven Wishbone stimulus, and is usable both in simulation and in on-chip self-test. Unlike the fixed 32-bit, single-access stimulus it replaces, it supports configurable data width, incrementing bursts, three run modes, a bus timeout and error logging.

## Interface
- `dw`, 32: Wishbone data width; legal values 8, 16, 32, 64.
- `aw`, 26: Wishbone byte-address width.
- `bl`, 5: burst-length field width; max burst = 2^bl − 1 beats.
- `nw`, 16: word-count width.
- `TO_CYC`, 255: ack timeout in `sys_clk` cycles.
- `sys_clk` in 1: single clock.
- `RESETN` in 1: asynchronous, active-low reset.
- `sdr_init_done` in 1: SDRAM initialisation complete.
- `start` in 1: one-cycle run request.
- `cfg_mode` in 2: 00 write-only, 01 read-check, 10 write-then-read, 11 reserved (treated as 10).
- `cfg_base_addr` in `aw`: start byte address; low log2(dw/8) bits ignored.
- `cfg_num_words` in `nw`: words to transfer.
- `cfg_burst_len` in `bl`: beats per burst; 0 is treated as 1.
- `cfg_seed` in `dw`: LFSR seed; all-zero is replaced by all-ones.
- `busy` out 1; `done` out 1 (one-cycle pulse); `timeout` out 1 (sticky until next start).
- `err_cnt` out 16: saturating mismatch count.
- `first_err_addr` out `aw`: address of first mismatch.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1; `wb_addr_o` out `aw`; `wb_dat_o` out `dw`; `wb_sel_o` out `dw/8`; `wb_cti_o` out 3.
- `wb_ack_i` in 1; `wb_dat_i` in `dw`.

## Operation
- States: IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FINISH.
- IDLE: `start` latches all `cfg_*`, clears `err_cnt`, `timeout` and `first_err_addr`, and goes to WAIT_INIT. `start` while `busy` is ignored.
- WAIT_INIT → WR_BURST (modes 00/10) or RD_BURST (01) once `sdr_init_done`=1. `cfg_num_words`=0 → FINISH directly, with no bus cycle.
- Burst: `cyc`=`stb`=1; beat count = min(`cfg_burst_len`, remaining words).
- `wb_cti_o` values: 000 if the burst is 1 beat; otherwise 010 on non-last beats and 111 on the last beat.
- `wb_sel_o` is all ones. `wb_we_o`=1 in WR_BURST, 0 in RD_BURST.
- Each ack advances the address by dw/8 (modulo 2^aw; wrap is allowed) and steps the LFSR.
- After the last beat of a burst: GAP state, with `cyc`=`stb`=0 for exactly one cycle. Then the next burst starts, or the phase ends.
- Write-phase end: mode 10 reloads the address and the LFSR seed and enters RD_BURST; mode 00 goes to FINISH.
- Read-phase end → FINISH.
- Read check: on each ack, compare `wb_dat_i` with the current LFSR value. On mismatch, `err_cnt` += 1 (saturating at 0xFFFF); the first mismatch captures `wb_addr_o`.
- LFSR: Galois, width `dw`, steps once per acked beat. Taps come from the package table.
- Timeout: a counter resets on every ack and runs while `stb`=1. When it reaches `TO_CYC`: drop `cyc`/`stb`, set `timeout`, go to FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.

## Timing
- All outputs are registered. Reset values: all 0, except `wb_cti_o`=000 and `wb_addr_o`=0.
- `busy` rises the cycle after `start` and falls together with the `done` pulse.
- Ack in cycle N → next beat's address/data/cti on `wb_*_o` in cycle N+1. Zero-wait-state slave: one beat per cycle.
- First `stb` no earlier than 2 cycles after `start` (IDLE→WAIT_INIT→burst).
- Asserting `RESETN` low mid-burst drops `cyc`/`stb` immediately (asynchronously) and returns the block to IDLE. No partial `done` is produced.
- `sdr_init_done` is sampled only in WAIT_INIT; a later deassertion has no effect.

## Structure
- Package `wb_sdr_pkg`: state enum, CTI constants (CLASSIC=000, INCR=010, EOB=111), mode enum, function `lfsr_taps(dw)`.
- Sub-module `wb_lfsr` (width param, load/step ports), instantiated once.

## Test plan
- Mode 10, dw=32, 16 words, burst 4, base 0x100, seed 0xACE1 with SDRAM model → 8 bursts, addresses 0x100–0x13C, `err_cnt`=0, `done` once.
- Same run with beat 5's read data forced to 0 → `err_cnt`=1, `first_err_addr`=0x114.
- 10 words, burst 4 → burst sizes 4,4,2, with cti 010,010,010,111 / …/ 010,111, and one idle cycle between bursts.
- `cfg_num_words`=0 → no `cyc`; `done` pulse 2 cycles after `start`.
- Slave never acks, `TO_CYC`=255 → `timeout`=1 after 255 stalled cycles, `cyc` drops, `done` pulses.
- `start` with `sdr_init_done`=0 for 100 cycles → no `stb` until it rises; `RESETN` pulsed low mid-burst → `cyc` drops immediately and `busy`=0.

Source files
------------

// File: rtl/wb_sdr_pkg.sv
// Shared definitions for the SDRAM Wishbone pattern master.
package wb_sdr_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_WAIT_INIT = 3'd1;
  localparam state_t S_WR_BURST  = 3'd2;
  localparam state_t S_WR_GAP    = 3'd3;
  localparam state_t S_RD_BURST  = 3'd4;
  localparam state_t S_RD_GAP    = 3'd5;
  localparam state_t S_FINISH    = 3'd6;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    MODE_WR    = 2'b00,
    MODE_RD    = 2'b01,
    MODE_WR_RD = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  // Galois feedback masks (right-shifting form) for maximal-length sequences
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0000_0000_8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/wb_lfsr.sv
// Galois LFSR that produces the write pattern and the read-back reference.
module wb_lfsr
  import wb_sdr_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [width-1:0] seed,
  output logic [width-1:0] state
);

  localparam logic [63:0]      TAPS_ALL = lfsr_taps(width);
  localparam logic [width-1:0] TAPS     = TAPS_ALL[width-1:0];

  // Load has priority so a reload and a final step never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/wb_sdr_pattern_master.sv
// Wishbone master that writes an LFSR pattern to SDRAM and checks it on read-back.
module wb_sdr_pattern_master
  import wb_sdr_pkg::*;
#(
  parameter int dw     = 32,
  parameter int aw     = 26,
  parameter int bl     = 5,
  parameter int nw     = 16,
  parameter int TO_CYC = 255
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            sdr_init_done,
  input  logic            start,
  input  logic [1:0]      cfg_mode,
  input  logic [aw-1:0]   cfg_base_addr,
  input  logic [nw-1:0]   cfg_num_words,
  input  logic [bl-1:0]   cfg_burst_len,
  input  logic [dw-1:0]   cfg_seed,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [15:0]     err_cnt,
  output logic [aw-1:0]   first_err_addr,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [aw-1:0]   wb_addr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [dw-1:0]   wb_dat_i
);

  localparam int            TW        = $clog2(TO_CYC + 1);
  localparam logic [aw-1:0] STEP      = aw'(dw / 8);
  localparam logic [aw-1:0] ALIGN_MSK = ~aw'(dw / 8 - 1);

  state_t          state;
  logic [1:0]      mode_r;
  logic [aw-1:0]   base_r;
  logic [nw-1:0]   num_r;
  logic [nw-1:0]   remaining;
  logic [bl-1:0]   blen_r;
  logic [bl-1:0]   beats_left;
  logic [dw-1:0]   seed_r;
  logic [TW-1:0]   to_cnt;
  logic            err_seen;

  logic            beat_ack;
  logic            do_launch;
  logic            launch_rd;
  logic [nw-1:0]   launch_words;
  logic [bl-1:0]   launch_beats;
  logic            lfsr_load;
  logic            lfsr_step;
  logic [dw-1:0]   lfsr_seed;
  logic [dw-1:0]   lfsr_q;
  logic [dw-1:0]   seed_fix;

  function automatic logic [bl-1:0] beats_for(input logic [nw-1:0] words,
                                              input logic [bl-1:0] blen);
    if (words < nw'(blen)) return bl'(words);
    return blen;
  endfunction

  assign beat_ack = wb_stb_o && wb_ack_i;
  assign seed_fix = (cfg_seed == '0) ? '1 : cfg_seed;
  assign wb_dat_o = lfsr_q;
  assign wb_sel_o = {(dw/8){wb_cyc_o}};

  // Decide whether a new burst starts this cycle and how large it is
  always_comb begin
    launch_words = remaining;
    launch_rd    = (state == S_RD_GAP);
    do_launch    = 1'b0;
    case (state)
      S_WAIT_INIT: begin
        launch_words = num_r;
        launch_rd    = (mode_r == MODE_RD);
        do_launch    = sdr_init_done && (num_r != '0);
      end
      S_WR_GAP: begin
        if (remaining == '0) begin
          launch_words = num_r;
          launch_rd    = 1'b1;
          do_launch    = mode_r[1];
        end else begin
          launch_rd    = 1'b0;
          do_launch    = 1'b1;
        end
      end
      S_RD_GAP: do_launch = (remaining != '0);
      default: ;
    endcase
    launch_beats = beats_for(launch_words, blen_r);
  end

  // LFSR is seeded at start and reseeded when the write phase hands over to reads
  always_comb begin
    lfsr_load = (state == S_IDLE && start) ||
                (state == S_WR_GAP && remaining == '0 && mode_r[1]);
    lfsr_seed = (state == S_IDLE) ? seed_fix : seed_r;
    lfsr_step = beat_ack && (state == S_WR_BURST || state == S_RD_BURST);
  end

  wb_lfsr #(.width(dw)) u_lfsr (
    .clk   (sys_clk),
    .rst_n (RESETN),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (lfsr_seed),
    .state (lfsr_q)
  );

  // Main sequencer: run control, bus handshake, timeout and read checking
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state          <= S_IDLE;
      mode_r         <= '0;
      base_r         <= '0;
      num_r          <= '0;
      remaining      <= '0;
      blen_r         <= '0;
      beats_left     <= '0;
      seed_r         <= '0;
      to_cnt         <= '0;
      err_seen       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_addr_o      <= '0;
      wb_cti_o       <= CTI_CLASSIC;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r         <= cfg_mode;
            base_r         <= cfg_base_addr & ALIGN_MSK;
            num_r          <= cfg_num_words;
            blen_r         <= (cfg_burst_len == '0) ? bl'(1) : cfg_burst_len;
            seed_r         <= seed_fix;
            err_cnt        <= '0;
            timeout        <= 1'b0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            busy           <= 1'b1;
            state          <= S_WAIT_INIT;
          end
        end
        S_WAIT_INIT: begin
          if (sdr_init_done) begin
            if (num_r == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FINISH;
            end else begin
              wb_addr_o <= base_r;
              remaining <= num_r;
            end
          end
        end
        S_WR_BURST, S_RD_BURST: begin
          if (beat_ack) begin
            wb_addr_o  <= wb_addr_o + STEP;
            remaining  <= remaining - 1'b1;
            beats_left <= beats_left - 1'b1;
            to_cnt     <= '0;
            if (state == S_RD_BURST && wb_dat_i != lfsr_q) begin
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
              if (!err_seen) begin
                err_seen       <= 1'b1;
                first_err_addr <= wb_addr_o;
              end
            end
            if (beats_left == bl'(1)) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_we_o  <= 1'b0;
              wb_cti_o <= CTI_CLASSIC;
              state    <= (state == S_WR_BURST) ? S_WR_GAP : S_RD_GAP;
            end else begin
              wb_cti_o <= (beats_left == bl'(2)) ? CTI_EOB : CTI_INCR;
            end
          end else if (to_cnt == TW'(TO_CYC - 1)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_cti_o <= CTI_CLASSIC;
            timeout  <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_FINISH;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WR_GAP: begin
          if (remaining == '0) begin
            if (mode_r[1]) begin
              wb_addr_o <= base_r;
              remaining <= num_r;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FINISH;
            end
          end
        end
        S_RD_GAP: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      if (do_launch) begin
        beats_left <= launch_beats;
        wb_cti_o   <= (launch_beats == bl'(1)) ? CTI_CLASSIC : CTI_INCR;
        wb_cyc_o   <= 1'b1;
        wb_stb_o   <= 1'b1;
        wb_we_o    <= !launch_rd;
        to_cnt     <= '0;
        state      <= launch_rd ? S_RD_BURST : S_WR_BURST;
      end
    end
  end

endmodule
